// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo slice: read-mode codes,
// default geometry and a ceiling-log2 for deriving address widths.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO user (master) and sync_fifo (slave).
// SYNC_FIFO_STATS_EN adds the overflow/underflow/peak_level statistics.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
`ifdef SYNC_FIFO_STATS_EN
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   peak_level;

  modport master (
    output wr, rd, data_in,
    input  data_out, full, empty, almost_full, almost_empty, level,
    input  overflow, underflow, peak_level
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, full, empty, almost_full, almost_empty, level,
    output overflow, underflow, peak_level
  );
`else
  modport master (
    output wr, rd, data_in,
    input  data_out, full, empty, almost_full, almost_empty, level
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, full, empty, almost_full, almost_empty, level
  );
`endif

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port,
// written so that iCE40 tools map the array onto EBR.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = 1 << DEFAULT_ADDR_WIDTH,
  localparam int AW         = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; a reset term would stop it mapping onto
  // block RAM and would cost a clear loop over every word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is cleared, so data_out reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO using all 2^ADDR_WIDTH slots, with level, almost flags and
// optional FWFT read mode. SYNC_FIFO_STATS_EN adds sticky error/peak stats.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input logic       clk,
  input logic       reset,
  sync_fifo_if.slave bus
);

  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH outside 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH outside 0..DEPTH");
  end

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, level;
  logic                  ram_empty, full, empty;
  logic                  wr_acc, rd_acc, ram_re;
  logic [DATA_WIDTH-1:0] ram_q;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign wr_acc    = bus.wr && !full;
  assign rd_acc    = bus.rd && !empty;

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    logic head_valid;

    // The RAM read register doubles as the head register: refill it whenever
    // it is vacant or being popped and the RAM has a word to give.
    assign ram_re = !ram_empty && (!head_valid || rd_acc);
    assign empty  = !head_valid;
    assign full   = (level == DEPTH_L);

    always_ff @(posedge clk) begin
      if (reset)       head_valid <= 1'b0;
      else if (ram_re) head_valid <= 1'b1;
      else if (rd_acc) head_valid <= 1'b0;
    end
  end else begin : g_std
    assign ram_re = rd_acc;
    assign empty  = ram_empty;
    assign full   = ((wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_re) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.data_in),
    .re    (ram_re),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  assign bus.data_out     = ram_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = level;
  assign bus.almost_full  = (int'(level) >= AF_THRESH);
  assign bus.almost_empty = (int'(level) <= AE_THRESH);

`ifdef SYNC_FIFO_STATS_EN
  logic                overflow, underflow;
  logic [ADDR_WIDTH:0] peak_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      peak_level <= '0;
    end else begin
      if (bus.wr && full)      overflow   <= 1'b1;
      if (bus.rd && empty)     underflow  <= 1'b1;
      if (level > peak_level)  peak_level <= level;
    end
  end

  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;
  assign bus.peak_level = peak_level;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-mode and one FWFT instance,
// DEPTH 4, AF_THRESH 3, AE_THRESH 1; stats checked when SYNC_FIFO_STATS_EN.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_std  ();
  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_fwft ();

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_std (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_std)
  );

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fwft)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic std_drive(input logic wr, input logic rd, input logic [7:0] d);
    bus_std.wr      = wr;
    bus_std.rd      = rd;
    bus_std.data_in = d;
  endtask

  task automatic fwft_drive(input logic wr, input logic rd, input logic [7:0] d);
    bus_fwft.wr      = wr;
    bus_fwft.rd      = rd;
    bus_fwft.data_in = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [7:0] fill_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [2:0] fill_level[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic       fill_af   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       fill_ae   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       fill_full [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    std_drive(1'b0, 1'b0, 8'h00);
    fwft_drive(1'b0, 1'b0, 8'h00);
    do_reset();

    // Reset state of both instances
    check("rst_level",   bus_std.level,        0);
    check("rst_empty",   bus_std.empty,        1);
    check("rst_full",    bus_std.full,         0);
    check("rst_ae",      bus_std.almost_empty, 1);
    check("rst_af",      bus_std.almost_full,  0);
    check("rst_dout",    bus_std.data_out,     0);
    check("rst_f_empty", bus_fwft.empty,       1);
    check("rst_f_level", bus_fwft.level,       0);
`ifdef SYNC_FIFO_STATS_EN
    check("rst_ovf",  bus_std.overflow,   0);
    check("rst_unf",  bus_std.underflow,  0);
    check("rst_peak", bus_std.peak_level, 0);
`endif

    // 1. Fill to DEPTH, then one dropped write
    for (int i = 0; i < 5; i++) begin
      std_drive(1'b1, 1'b0, fill_data[i]);
      step();
      check($sformatf("fill%0d_level", i), bus_std.level,        fill_level[i]);
      check($sformatf("fill%0d_af", i),    bus_std.almost_full,  fill_af[i]);
      check($sformatf("fill%0d_ae", i),    bus_std.almost_empty, fill_ae[i]);
      check($sformatf("fill%0d_full", i),  bus_std.full,         fill_full[i]);
    end

    // 2. Drain in order, then a read while empty leaves data_out alone
    for (int i = 0; i < 4; i++) begin
      std_drive(1'b0, 1'b1, 8'h00);
      step();
      check($sformatf("drain%0d_dout", i),  bus_std.data_out, fill_data[i]);
      check($sformatf("drain%0d_level", i), bus_std.level,    3 - i);
    end
    check("drain_empty", bus_std.empty, 1);
    step();
    check("extra_rd_dout",  bus_std.data_out, 8'h44);
    check("extra_rd_level", bus_std.level,    0);
`ifdef SYNC_FIFO_STATS_EN
    check("run_ovf",  bus_std.overflow,   1);
    check("run_unf",  bus_std.underflow,  1);
    check("run_peak", bus_std.peak_level, 4);
`endif

    // 3. Simultaneous write and read at level 2
    std_drive(1'b1, 1'b0, 8'hB1); step();
    std_drive(1'b1, 1'b0, 8'hB2); step();
    check("sim_pre_level", bus_std.level, 2);
    std_drive(1'b1, 1'b1, 8'hA5); step();
    check("sim_level", bus_std.level,    2);
    check("sim_dout",  bus_std.data_out, 8'hB1);
    std_drive(1'b0, 1'b1, 8'h00); step();
    check("sim_rd1", bus_std.data_out, 8'hB2);
    step();
    check("sim_rd2",   bus_std.data_out, 8'hA5);
    check("sim_empty", bus_std.empty,    1);

    // 4. Ten write/read pairs carry both pointers across the wrap
    for (int i = 0; i < 10; i++) begin
      std_drive(1'b1, 1'b0, 8'(i)); step();
      check($sformatf("wrap%0d_full", i),  bus_std.full,  0);
      check($sformatf("wrap%0d_level", i), bus_std.level, 1);
      std_drive(1'b0, 1'b1, 8'h00); step();
      check($sformatf("wrap%0d_dout", i),  bus_std.data_out, i);
      check($sformatf("wrap%0d_empty", i), bus_std.empty,    1);
    end
    // After the wrap, full must appear only on the fourth word
    for (int i = 0; i < 4; i++) begin
      std_drive(1'b1, 1'b0, 8'hE0 + 8'(i)); step();
      check($sformatf("wfill%0d_full", i), bus_std.full, (i == 3) ? 1 : 0);
    end
    std_drive(1'b0, 1'b1, 8'h00); step();
    check("wfill_dout", bus_std.data_out, 8'hE0);

    // Reset mid-operation discards contents and clears data_out
    std_drive(1'b0, 1'b0, 8'h00);
    do_reset();
    check("mid_rst_level", bus_std.level,    0);
    check("mid_rst_dout",  bus_std.data_out, 0);
    check("mid_rst_empty", bus_std.empty,    1);
    check("mid_rst_full",  bus_std.full,     0);
`ifdef SYNC_FIFO_STATS_EN
    check("mid_rst_ovf",  bus_std.overflow,   0);
    check("mid_rst_unf",  bus_std.underflow,  0);
    check("mid_rst_peak", bus_std.peak_level, 0);

    // 6. Stats: overflow, underflow and peak, then cleared by reset
    for (int i = 0; i < 5; i++) begin
      std_drive(1'b1, 1'b0, fill_data[i]); step();
    end
    check("st_ovf_set", bus_std.overflow, 1);
    check("st_unf_clr", bus_std.underflow, 0);
    for (int i = 0; i < 5; i++) begin
      std_drive(1'b0, 1'b1, 8'h00); step();
    end
    std_drive(1'b0, 1'b0, 8'h00);
    check("st_ovf",  bus_std.overflow,   1);
    check("st_unf",  bus_std.underflow,  1);
    check("st_peak", bus_std.peak_level, 4);
    do_reset();
    check("st_rst_ovf",  bus_std.overflow,   0);
    check("st_rst_unf",  bus_std.underflow,  0);
    check("st_rst_peak", bus_std.peak_level, 0);
`endif

    // 5. FWFT: word written at edge N is visible after N+1 without rd
    fwft_drive(1'b1, 1'b0, 8'h5A); step();
    check("fw_n_level", bus_fwft.level, 1);
    check("fw_n_empty", bus_fwft.empty, 1);
    fwft_drive(1'b0, 1'b0, 8'h00); step();
    check("fw_n1_empty", bus_fwft.empty,    0);
    check("fw_n1_dout",  bus_fwft.data_out, 8'h5A);
    step();
    check("fw_hold_dout", bus_fwft.data_out, 8'h5A);
    fwft_drive(1'b0, 1'b1, 8'h00); step();
    check("fw_pop_empty", bus_fwft.empty, 1);
    check("fw_pop_level", bus_fwft.level, 0);

    // FWFT fill to DEPTH counting the head register, then pop in order
    for (int i = 0; i < 5; i++) begin
      fwft_drive(1'b1, 1'b0, 8'hC1 + 8'(i)); step();
    end
    fwft_drive(1'b0, 1'b0, 8'h00);
    check("fw_full",  bus_fwft.full,     1);
    check("fw_level", bus_fwft.level,    4);
    check("fw_head",  bus_fwft.data_out, 8'hC1);
    for (int i = 0; i < 3; i++) begin
      fwft_drive(1'b0, 1'b1, 8'h00); step();
      check($sformatf("fw_pop%0d_dout", i),  bus_fwft.data_out, 8'hC2 + 8'(i));
      check($sformatf("fw_pop%0d_level", i), bus_fwft.level,    3 - i);
      check($sformatf("fw_pop%0d_empty", i), bus_fwft.empty,    0);
    end
    step();
    fwft_drive(1'b0, 1'b0, 8'h00);
    check("fw_last_empty", bus_fwft.empty, 1);
    check("fw_last_level", bus_fwft.level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
